mem_scheduler: RTL

//  Time-shares the single-port system RAM between three requesters:
//  - CPU: strobed by cpu_clken, highest priority.
//  - Video fetch: req/ack handshake.
//  - Loader / ioctl download: req/ack handshake, lowest priority.

---
 rtl/apple1_mem_pkg.sv | 8 +
 rtl/mem_scheduler_if.sv | 43 ++++
 rtl/mem_prio_select.sv | 36 +++
 rtl/mem_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/apple1_mem_pkg.sv
// Shared types and default widths for the system RAM scheduler.
package apple1_mem_pkg;
   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, CAPTURE} state_t;
   typedef enum logic [1:0] {REQ_CPU, REQ_VID, REQ_LDR} req_id_t;
endpackage

// File: rtl/mem_scheduler_if.sv
// Requester and RAM signal bundle for mem_scheduler; slave = scheduler, master = environment.
// Handshake: vid_req/ldr_req are levels held with their addr/wdata until the one-cycle ack;
// dropping req before the grant withdraws it, dropping it after the grant does not cancel the access.
interface mem_scheduler_if
   import apple1_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              cpu_clken;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_we;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_done;
   logic              cpu_overrun;
   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_ack;
   logic [DATA_W-1:0] vid_rdata;
   logic              ldr_req;
   logic [ADDR_W-1:0] ldr_addr;
   logic [DATA_W-1:0] ldr_wdata;
   logic              ldr_ack;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  cpu_clken, cpu_addr, cpu_wdata, cpu_we, vid_req, vid_addr,
             ldr_req, ldr_addr, ldr_wdata, ram_rdata,
      output cpu_rdata, cpu_done, cpu_overrun, vid_ack, vid_rdata, ldr_ack,
             ram_addr, ram_wdata, ram_we
   );

   modport master (
      output cpu_clken, cpu_addr, cpu_wdata, cpu_we, vid_req, vid_addr,
             ldr_req, ldr_addr, ldr_wdata, ram_rdata,
      input  cpu_rdata, cpu_done, cpu_overrun, vid_ack, vid_rdata, ldr_ack,
             ram_addr, ram_wdata, ram_we
   );
endinterface

// File: rtl/mem_prio_select.sv
// Fixed-priority picker (CPU > video > loader) with masking of the requester acked this cycle.
// Loader arbitration exists only when APPLE1_LOADER_EN is defined.
module mem_prio_select
   import apple1_mem_pkg::*;
(
   input  logic    cpu_req_i,
   input  logic    vid_req_i,
   input  logic    ldr_req_i,
   input  logic    cpu_mask_i,
   input  logic    vid_mask_i,
   input  logic    ldr_mask_i,
   output req_id_t sel_id_o,
   output logic    sel_valid_o
);
`ifndef APPLE1_LOADER_EN
   logic ldr_unused;
   assign ldr_unused = ldr_req_i | ldr_mask_i;
`endif

   always_comb begin
      sel_id_o    = REQ_CPU;
      sel_valid_o = 1'b0;
      if (cpu_req_i && !cpu_mask_i) begin
         sel_id_o    = REQ_CPU;
         sel_valid_o = 1'b1;
      end else if (vid_req_i && !vid_mask_i) begin
         sel_id_o    = REQ_VID;
         sel_valid_o = 1'b1;
`ifdef APPLE1_LOADER_EN
      end else if (ldr_req_i && !ldr_mask_i) begin
         sel_id_o    = REQ_LDR;
         sel_valid_o = 1'b1;
`endif
      end
   end
endmodule

// File: rtl/mem_scheduler.sv
// Time-shares the single-port system RAM between CPU, video fetch and loader.
// Loader port is arbitrated only when APPLE1_LOADER_EN is defined; otherwise ldr_ack is tied 0.
module mem_scheduler
   import apple1_mem_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int RAM_LATENCY = 1
)(
   input  logic            sys_clock,
   input  logic            reset_n,
   mem_scheduler_if.slave  bus,
   output state_t          state_o
);
   localparam logic [1:0] WAIT_LAST = 2'(RAM_LATENCY - 2);

   state_t            state_q, state_d;
   req_id_t           gnt_q, gnt_d;
   logic [1:0]        wait_cnt_q, wait_cnt_d;
   logic              cpu_pend_q, cpu_pend_d;
   logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
   logic [DATA_W-1:0] cpu_wdata_q, cpu_wdata_d;
   logic              cpu_we_q, cpu_we_d;
   logic              cpu_overrun_q, cpu_overrun_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              ram_we_q, ram_we_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic              cpu_done_q, cpu_done_d;
   logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
   logic              vid_ack_q, vid_ack_d;
   logic              ldr_ack_q, ldr_ack_d;
   logic              cpu_gnt;
   req_id_t           sel_id;
   logic              sel_valid;

   mem_prio_select u_prio (
      .cpu_req_i   (cpu_pend_q),
      .vid_req_i   (bus.vid_req),
      .ldr_req_i   (bus.ldr_req),
      .cpu_mask_i  (cpu_done_q),
      .vid_mask_i  (vid_ack_q),
      .ldr_mask_i  (ldr_ack_q),
      .sel_id_o    (sel_id),
      .sel_valid_o (sel_valid)
   );

`ifndef APPLE1_LOADER_EN
   logic ldr_unused;
   assign ldr_unused = ^{bus.ldr_addr, bus.ldr_wdata};
`endif

   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      wait_cnt_d    = wait_cnt_q;
      cpu_pend_d    = cpu_pend_q;
      cpu_addr_d    = cpu_addr_q;
      cpu_wdata_d   = cpu_wdata_q;
      cpu_we_d      = cpu_we_q;
      cpu_overrun_d = cpu_overrun_q;
      ram_addr_d    = ram_addr_q;
      ram_wdata_d   = ram_wdata_q;
      ram_we_d      = 1'b0;
      cpu_rdata_d   = cpu_rdata_q;
      cpu_done_d    = 1'b0;
      vid_rdata_d   = vid_rdata_q;
      vid_ack_d     = 1'b0;
      ldr_ack_d     = 1'b0;
      cpu_gnt       = 1'b0;

      case (state_q)
         IDLE: begin
            if (sel_valid) begin
               state_d = ACCESS;
               gnt_d   = sel_id;
               case (sel_id)
                  REQ_CPU: begin
                     ram_addr_d  = cpu_addr_q;
                     ram_wdata_d = cpu_wdata_q;
                     ram_we_d    = cpu_we_q;
                     cpu_gnt     = 1'b1;
                  end
                  REQ_VID: begin
                     ram_addr_d = bus.vid_addr;
                  end
`ifdef APPLE1_LOADER_EN
                  REQ_LDR: begin
                     ram_addr_d  = bus.ldr_addr;
                     ram_wdata_d = bus.ldr_wdata;
                     ram_we_d    = 1'b1;
                  end
`endif
                  default: ;
               endcase
            end
         end
         ACCESS: begin
            wait_cnt_d = 2'd0;
            state_d    = (RAM_LATENCY > 1) ? WAIT : CAPTURE;
         end
         WAIT: begin
            wait_cnt_d = wait_cnt_q + 2'd1;
            if (wait_cnt_q == WAIT_LAST) state_d = CAPTURE;
         end
         CAPTURE: begin
            state_d = IDLE;
            case (gnt_q)
               REQ_CPU: begin
                  cpu_rdata_d = bus.ram_rdata;
                  cpu_done_d  = 1'b1;
               end
               REQ_VID: begin
                  vid_rdata_d = bus.ram_rdata;
                  vid_ack_d   = 1'b1;
               end
`ifdef APPLE1_LOADER_EN
               REQ_LDR: ldr_ack_d = 1'b1;
`endif
               default: ;
            endcase
         end
         default: state_d = IDLE;
      endcase

      // A strobe in the grant cycle refills the pending slot; otherwise it overwrites an unserved request.
      if (cpu_gnt) cpu_pend_d = 1'b0;
      if (bus.cpu_clken) begin
         if (cpu_pend_q && !cpu_gnt) cpu_overrun_d = 1'b1;
         cpu_pend_d  = 1'b1;
         cpu_addr_d  = bus.cpu_addr;
         cpu_wdata_d = bus.cpu_wdata;
         cpu_we_d    = bus.cpu_we;
      end
   end

   always_ff @(posedge sys_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         gnt_q         <= REQ_CPU;
         wait_cnt_q    <= '0;
         cpu_pend_q    <= 1'b0;
         cpu_addr_q    <= '0;
         cpu_wdata_q   <= '0;
         cpu_we_q      <= 1'b0;
         cpu_overrun_q <= 1'b0;
         ram_addr_q    <= '0;
         ram_wdata_q   <= '0;
         ram_we_q      <= 1'b0;
         cpu_rdata_q   <= '0;
         cpu_done_q    <= 1'b0;
         vid_rdata_q   <= '0;
         vid_ack_q     <= 1'b0;
         ldr_ack_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         wait_cnt_q    <= wait_cnt_d;
         cpu_pend_q    <= cpu_pend_d;
         cpu_addr_q    <= cpu_addr_d;
         cpu_wdata_q   <= cpu_wdata_d;
         cpu_we_q      <= cpu_we_d;
         cpu_overrun_q <= cpu_overrun_d;
         ram_addr_q    <= ram_addr_d;
         ram_wdata_q   <= ram_wdata_d;
         ram_we_q      <= ram_we_d;
         cpu_rdata_q   <= cpu_rdata_d;
         cpu_done_q    <= cpu_done_d;
         vid_rdata_q   <= vid_rdata_d;
         vid_ack_q     <= vid_ack_d;
         ldr_ack_q     <= ldr_ack_d;
      end
   end

   assign bus.cpu_rdata   = cpu_rdata_q;
   assign bus.cpu_done    = cpu_done_q;
   assign bus.cpu_overrun = cpu_overrun_q;
   assign bus.vid_rdata   = vid_rdata_q;
   assign bus.vid_ack     = vid_ack_q;
   assign bus.ram_addr    = ram_addr_q;
   assign bus.ram_wdata   = ram_wdata_q;
   assign bus.ram_we      = ram_we_q;
   assign state_o         = state_q;
`ifdef APPLE1_LOADER_EN
   assign bus.ldr_ack = ldr_ack_q;
`else
   assign bus.ldr_ack = 1'b0;
`endif
endmodule
